// File: rtl/bbox_msg_reader_pkg.sv
// rtl/bbox_msg_reader_pkg.sv - register map, message IDs and shared types for the bbox reader
package bbox_msg_reader_pkg;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_MSG    = 3'd1;
  localparam logic [2:0] ADDR_ID     = 3'd2;

  localparam int          FLUSH_BIT  = 4;
  localparam logic [31:0] FLUSH_WORD = 32'(1) << FLUSH_BIT;

  localparam logic [31:0] MSG_ID_RBB = 32'h0052_4242;
  localparam logic [31:0] MSG_ID_YBB = 32'h0059_4242;
  localparam logic [31:0] MSG_ID_GBB = 32'h0047_4242;

  typedef enum logic [1:0] {
    COLOR_RED    = 2'd0,
    COLOR_YELLOW = 2'd1,
    COLOR_BLUE   = 2'd2
  } color_e;

  typedef enum logic [3:0] {
    ST_ID_RD,
    ST_ID_WAIT,
    ST_ID_HOLD,
    ST_IDLE,
    ST_ST_RD,
    ST_ST_WAIT,
    ST_GAP,
    ST_MG_RD,
    ST_MG_WAIT,
    ST_EMIT,
    ST_FL_WR
  } state_e;

  typedef struct packed {
    logic        id_hit;
    color_e      color;
    logic [10:0] x;
    logic [10:0] y;
    logic        malformed;
  } word_info_t;

endpackage

// File: rtl/bbox_msg_reader_if.sv
// rtl/bbox_msg_reader_if.sv - MM bus between the bbox reader (master) and the vision core (slave)
interface bbox_msg_reader_if;
  logic [2:0]  m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  modport master (
    output m_address, m_read, m_write, m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_read, m_write, m_writedata,
    output m_readdata
  );
endinterface

// File: rtl/bbox_msg_reader_word_decoder.sv
// rtl/bbox_msg_reader_word_decoder.sv - classifies one FIFO word by its position in the message
module bbox_word_decoder
  import bbox_msg_reader_pkg::*;
#(
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480
) (
  input  logic [31:0] word,
  input  logic [1:0]  index,
  output word_info_t  info
);

  localparam logic [10:0] X_LIM = 11'(IMAGE_W);
  localparam logic [10:0] Y_LIM = 11'(IMAGE_H);

  always_comb begin
    info   = '0;
    info.x = word[26:16];
    info.y = word[10:0];
    if (index == 2'd0) begin
      case (word)
        MSG_ID_RBB: begin info.id_hit = 1'b1; info.color = COLOR_RED;    end
        MSG_ID_YBB: begin info.id_hit = 1'b1; info.color = COLOR_YELLOW; end
        MSG_ID_GBB: begin info.id_hit = 1'b1; info.color = COLOR_BLUE;   end
        default:    info.malformed = 1'b1;
      endcase
    end else begin
      // Padding bits must be clear and the corner must lie inside the image.
      info.malformed = (word[31:27] != 5'd0) || (word[15:11] != 5'd0) ||
                       (word[26:16] >= X_LIM) || (word[10:0] >= Y_LIM);
    end
  end

endmodule

// File: rtl/bbox_msg_reader.sv
// rtl/bbox_msg_reader.sv - checks the core ID, polls the message FIFO and emits decoded boxes
module bbox_msg_reader
  import bbox_msg_reader_pkg::*;
#(
  parameter int          POLL_INTERVAL = 1024,
  parameter int          IMAGE_W       = 640,
  parameter int          IMAGE_H       = 480,
  parameter logic [31:0] CORE_ID       = 32'h1234EEE2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  bbox_msg_reader_if.master         bus,
  input  logic                      flush_req,
  output logic                      id_ok,
  output logic                      box_valid,
  output logic [1:0]                box_color,
  output logic [10:0]               box_x_min,
  output logic [10:0]               box_y_min,
  output logic [10:0]               box_x_max,
  output logic [10:0]               box_y_max,
  output logic                      box_empty,
  output logic [7:0]                err_count
);

  localparam int             TW        = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TW-1:0]  TIMER_END = TW'(POLL_INTERVAL - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [2:0]    m_address_q, m_address_d;
  logic          m_read_q, m_read_d;
  logic          m_write_q, m_write_d;
  logic [31:0]   m_writedata_q, m_writedata_d;
  logic          id_ok_q, id_ok_d;
  logic          box_valid_q, box_valid_d;
  color_e        box_color_q, box_color_d;
  logic [10:0]   box_x_min_q, box_x_min_d;
  logic [10:0]   box_y_min_q, box_y_min_d;
  logic [10:0]   box_x_max_q, box_x_max_d;
  logic [10:0]   box_y_max_q, box_y_max_d;
  logic [7:0]    err_q, err_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    remaining_q, remaining_d;
  color_e        stage_color_q, stage_color_d;
  logic [10:0]   stage_x_q, stage_x_d;
  logic [10:0]   stage_y_q, stage_y_d;
  logic          flush_pend_q, flush_pend_d;

  word_info_t    dec;
  logic          bad_word;

  bbox_word_decoder #(
    .IMAGE_W (IMAGE_W),
    .IMAGE_H (IMAGE_H)
  ) u_decoder (
    .word  (bus.m_readdata),
    .index (idx_q),
    .info  (dec)
  );

  assign bad_word = dec.malformed || ((idx_q == 2'd0) && !dec.id_hit);

  always_comb begin
    state_d       = state_q;
    timer_d       = '0;
    rsp_valid_d   = m_read_q;
    m_address_d   = m_address_q;
    m_read_d      = 1'b0;
    m_write_d     = 1'b0;
    m_writedata_d = m_writedata_q;
    id_ok_d       = id_ok_q;
    box_valid_d   = 1'b0;
    box_color_d   = box_color_q;
    box_x_min_d   = box_x_min_q;
    box_y_min_d   = box_y_min_q;
    box_x_max_d   = box_x_max_q;
    box_y_max_d   = box_y_max_q;
    err_d         = err_q;
    idx_d         = idx_q;
    remaining_d   = remaining_q;
    stage_color_d = stage_color_q;
    stage_x_d     = stage_x_q;
    stage_y_d     = stage_y_q;
    flush_pend_d  = flush_pend_q | flush_req;

    // Strobes are registered, so each *_WAIT state sees its response one cycle after the strobe.
    case (state_q)
      ST_ID_RD: begin
        m_read_d    = 1'b1;
        m_address_d = ADDR_ID;
        state_d     = ST_ID_WAIT;
      end
      ST_ID_WAIT: begin
        if (rsp_valid_q) begin
          id_ok_d = (bus.m_readdata == CORE_ID);
          state_d = (bus.m_readdata == CORE_ID) ? ST_IDLE : ST_ID_HOLD;
        end
      end
      ST_ID_HOLD: begin
        if (timer_q == TIMER_END) state_d = ST_ID_RD;
        else                      timer_d = timer_q + 1'b1;
      end
      ST_IDLE: begin
        if (flush_pend_q)               state_d = ST_FL_WR;
        else if (timer_q == TIMER_END)  state_d = ST_ST_RD;
        else                            timer_d = timer_q + 1'b1;
      end
      ST_ST_RD: begin
        m_read_d    = 1'b1;
        m_address_d = ADDR_STATUS;
        state_d     = ST_ST_WAIT;
      end
      ST_ST_WAIT: begin
        if (rsp_valid_q) begin
          remaining_d = bus.m_readdata[15:8];
          state_d     = (bus.m_readdata[15:8] >= 8'd3) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: state_d = ST_MG_RD;
      ST_MG_RD: begin
        m_read_d    = 1'b1;
        m_address_d = ADDR_MSG;
        remaining_d = remaining_q - 8'd1;
        state_d     = ST_MG_WAIT;
      end
      ST_MG_WAIT: begin
        if (rsp_valid_q) begin
          state_d = (remaining_q != 8'd0) ? ST_GAP : ST_IDLE;
          if (bad_word) begin
            // Dropping back to index 0 lets a desynchronised stream rescan word by word.
            idx_d = 2'd0;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end else begin
            case (idx_q)
              2'd0: begin
                stage_color_d = dec.color;
                idx_d         = 2'd1;
              end
              2'd1: begin
                stage_x_d = dec.x;
                stage_y_d = dec.y;
                idx_d     = 2'd2;
              end
              default: begin
                box_valid_d = 1'b1;
                box_color_d = stage_color_q;
                box_x_min_d = stage_x_q;
                box_y_min_d = stage_y_q;
                box_x_max_d = dec.x;
                box_y_max_d = dec.y;
                idx_d       = 2'd0;
                state_d     = ST_EMIT;
              end
            endcase
          end
        end
      end
      ST_EMIT: state_d = (remaining_q >= 8'd3) ? ST_GAP : ST_IDLE;
      ST_FL_WR: begin
        m_write_d     = 1'b1;
        m_address_d   = ADDR_STATUS;
        m_writedata_d = FLUSH_WORD;
        idx_d         = 2'd0;
        flush_pend_d  = flush_req;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_ID_RD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_ID_RD;
      timer_q       <= '0;
      rsp_valid_q   <= 1'b0;
      m_address_q   <= 3'd0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_writedata_q <= 32'd0;
      id_ok_q       <= 1'b0;
      box_valid_q   <= 1'b0;
      box_color_q   <= COLOR_RED;
      box_x_min_q   <= 11'd0;
      box_y_min_q   <= 11'd0;
      box_x_max_q   <= 11'd0;
      box_y_max_q   <= 11'd0;
      err_q         <= 8'd0;
      idx_q         <= 2'd0;
      remaining_q   <= 8'd0;
      stage_color_q <= COLOR_RED;
      stage_x_q     <= 11'd0;
      stage_y_q     <= 11'd0;
      flush_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rsp_valid_q   <= rsp_valid_d;
      m_address_q   <= m_address_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
      m_writedata_q <= m_writedata_d;
      id_ok_q       <= id_ok_d;
      box_valid_q   <= box_valid_d;
      box_color_q   <= box_color_d;
      box_x_min_q   <= box_x_min_d;
      box_y_min_q   <= box_y_min_d;
      box_x_max_q   <= box_x_max_d;
      box_y_max_q   <= box_y_max_d;
      err_q         <= err_d;
      idx_q         <= idx_d;
      remaining_q   <= remaining_d;
      stage_color_q <= stage_color_d;
      stage_x_q     <= stage_x_d;
      stage_y_q     <= stage_y_d;
      flush_pend_q  <= flush_pend_d;
    end
  end

  assign bus.m_address   = m_address_q;
  assign bus.m_read      = m_read_q;
  assign bus.m_write     = m_write_q;
  assign bus.m_writedata = m_writedata_q;
  assign id_ok           = id_ok_q;
  assign box_valid       = box_valid_q;
  assign box_color       = box_color_q;
  assign box_x_min       = box_x_min_q;
  assign box_y_min       = box_y_min_q;
  assign box_x_max       = box_x_max_q;
  assign box_y_max       = box_y_max_q;
  assign box_empty       = (box_x_min_q > box_x_max_q) || (box_y_min_q > box_y_max_q);
  assign err_count       = err_q;

endmodule

// File: tb/tb_bbox_msg_reader.sv
// tb/tb_bbox_msg_reader.sv - directed bench with a behavioural vision-core slave
module tb_bbox_msg_reader;
  import bbox_msg_reader_pkg::*;

  localparam int P = 16;
  localparam logic [31:0] CID = 32'h1234EEE2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush_req = 1'b0;
  logic        id_ok, box_valid, box_empty;
  logic [1:0]  box_color;
  logic [10:0] box_x_min, box_y_min, box_x_max, box_y_max;
  logic [7:0]  err_count;

  bbox_msg_reader_if bus ();

  always #5 clk = ~clk;

  bbox_msg_reader #(.POLL_INTERVAL(P), .IMAGE_W(640), .IMAGE_H(480), .CORE_ID(CID)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .flush_req (flush_req),
    .id_ok     (id_ok),
    .box_valid (box_valid),
    .box_color (box_color),
    .box_x_min (box_x_min),
    .box_y_min (box_y_min),
    .box_x_max (box_x_max),
    .box_y_max (box_y_max),
    .box_empty (box_empty),
    .err_count (err_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] id_value = 32'hDEADBEEF;
  logic [31:0] fifo_q[$];
  int cyc = 0;
  int rd_cnt[3] = '{0, 0, 0};
  int rd_total = 0, wr_cnt = 0, box_cnt = 0, rw_overlap = 0;
  int last_rd_cyc = -1000, min_rd_gap = 1000;
  int prev_id_cyc = -1000, id_gap = 0, first_st_cyc = -1;
  int last_msg_cyc = 0, last_wr_cyc = 0;
  logic [2:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [1:0]  cap_color = '0;
  logic [10:0] cap_x0 = '0, cap_y0 = '0, cap_x1 = '0, cap_y1 = '0;
  logic        cap_empty = 1'b0;

  initial bus.m_readdata = 32'd0;

  // Slave model and bus monitor: responses become visible before the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (bus.m_read) begin
      if (cyc - last_rd_cyc < min_rd_gap) min_rd_gap = cyc - last_rd_cyc;
      last_rd_cyc  = cyc;
      last_rd_addr = bus.m_address;
      rd_total++;
      case (bus.m_address)
        3'd0: begin
          rd_cnt[0]++;
          if (first_st_cyc < 0) first_st_cyc = cyc;
          bus.m_readdata = {16'd0, 8'(fifo_q.size()), 8'd0};
        end
        3'd1: begin
          rd_cnt[1]++;
          last_msg_cyc = cyc;
          bus.m_readdata = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'd0;
        end
        3'd2: begin
          rd_cnt[2]++;
          id_gap = cyc - prev_id_cyc;
          prev_id_cyc = cyc;
          bus.m_readdata = id_value;
        end
        default: bus.m_readdata = 32'd0;
      endcase
    end
    if (bus.m_write) begin
      wr_cnt++;
      last_wr_cyc  = cyc;
      last_wr_addr = bus.m_address;
      last_wr_data = bus.m_writedata;
      if (bus.m_read) rw_overlap++;
      if (bus.m_address == 3'd0 && bus.m_writedata[4]) fifo_q.delete();
    end
    if (box_valid) begin
      box_cnt++;
      cap_color = box_color;
      cap_x0 = box_x_min; cap_y0 = box_y_min;
      cap_x1 = box_x_max; cap_y1 = box_y_max;
      cap_empty = box_empty;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rd(input int a, input int n, input int budget, input string tag);
    int k = 0;
    while (rd_cnt[a] < n && k < budget) begin tick(); k++; end
    check(tag, rd_cnt[a] >= n, 1);
  endtask

  task automatic wait_box(input int n, input int budget, input string tag);
    int k = 0;
    while (box_cnt < n && k < budget) begin tick(); k++; end
    check(tag, box_cnt >= n, 1);
  endtask

  function automatic logic [31:0] corner(input int x, input int y);
    return {5'd0, 11'(x), 5'd0, 11'(y)};
  endfunction

  initial begin
    int k, id_cyc, e0, b0, m0, w0, t0;

    repeat (3) tick();
    check("rst_id_ok", id_ok, 0);
    check("rst_m_read", bus.m_read, 0);
    check("rst_m_write", bus.m_write, 0);
    check("rst_m_address", bus.m_address, 0);
    check("rst_m_writedata", bus.m_writedata, 0);
    check("rst_err_count", err_count, 0);
    check("rst_box_valid", box_valid, 0);
    reset_n = 1'b1;

    // Wrong core ID: retried after the hold interval, status never polled.
    wait_rd(2, 2, 10 * P, "id_retry_seen");
    check("id_bad_id_ok", id_ok, 0);
    check("id_retry_gap_in_range", (id_gap >= P) && (id_gap <= P + 4), 1);
    check("id_bad_no_status", rd_cnt[0], 0);

    id_value = CID;
    first_st_cyc = -1;
    k = 0;
    while (!id_ok && k < 10 * P) begin tick(); k++; end
    check("id_ok_set", id_ok, 1);
    id_cyc = cyc;
    wait_rd(0, 1, 4 * P, "first_status_seen");
    check("first_poll_delay", (first_st_cyc - id_cyc >= P) && (first_st_cyc - id_cyc <= P + 2), 1);

    // Nominal red box.
    e0 = err_count; b0 = box_cnt;
    fifo_q.push_back(MSG_ID_RBB);
    fifo_q.push_back(corner(100, 50));
    fifo_q.push_back(corner(200, 120));
    wait_box(b0 + 1, 6 * P, "nom_box_seen");
    repeat (5) tick();
    check("nom_box_pulses", box_cnt - b0, 1);
    check("nom_color", cap_color, 0);
    check("nom_x_min", cap_x0, 100);
    check("nom_y_min", cap_y0, 50);
    check("nom_x_max", cap_x1, 200);
    check("nom_y_max", cap_y1, 120);
    check("nom_empty", cap_empty, 0);
    check("nom_err", err_count, e0);
    check("nom_read_spacing", min_rd_gap >= 2, 1);
    check("nom_held_x_max", box_x_max, 200);

    // Inverted corners give an empty yellow box.
    b0 = box_cnt;
    fifo_q.push_back(MSG_ID_YBB);
    fifo_q.push_back(corner(639, 479));
    fifo_q.push_back(corner(0, 0));
    wait_box(b0 + 1, 6 * P, "empty_box_seen");
    check("empty_color", cap_color, 1);
    check("empty_x_min", cap_x0, 639);
    check("empty_flag", cap_empty, 1);
    check("empty_err", err_count, e0);

    // Two junk words ahead of a blue box.
    b0 = box_cnt;
    fifo_q.push_back(32'h0000_0123);
    fifo_q.push_back(32'h0000_0456);
    fifo_q.push_back(MSG_ID_GBB);
    fifo_q.push_back(corner(10, 10));
    fifo_q.push_back(corner(20, 20));
    wait_box(b0 + 1, 8 * P, "resync_box_seen");
    repeat (5) tick();
    check("resync_err", err_count, e0 + 2);
    check("resync_color", cap_color, 2);
    check("resync_x_max", cap_x1, 20);
    check("resync_pulses", box_cnt - b0, 1);

    // Two words are not enough to start draining; a third out-of-range word is rejected.
    e0 = err_count; b0 = box_cnt; m0 = rd_cnt[1]; t0 = rd_cnt[0];
    fifo_q.push_back(MSG_ID_RBB);
    fifo_q.push_back(corner(1, 1));
    repeat (4 * P) tick();
    check("short_no_msg_reads", rd_cnt[1] - m0, 0);
    check("short_polled", rd_cnt[0] - t0 >= 2, 1);
    fifo_q.push_back(corner(700, 5));
    wait_rd(1, m0 + 3, 6 * P, "range_reads_seen");
    repeat (6) tick();
    check("range_err", err_count, e0 + 1);
    check("range_no_box", box_cnt, b0);
    check("range_fifo_drained", fifo_q.size(), 0);

    // Flush requested mid-message: the message finishes, then one flush write.
    b0 = box_cnt; w0 = wr_cnt; m0 = rd_cnt[1];
    fifo_q.push_back(MSG_ID_RBB);
    fifo_q.push_back(corner(1, 2));
    fifo_q.push_back(corner(3, 4));
    wait_rd(1, m0 + 1, 6 * P, "flush_first_read");
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    k = 0;
    while (wr_cnt == w0 && k < 6 * P) begin tick(); k++; end
    repeat (2 * P) tick();
    check("flush_write_count", wr_cnt - w0, 1);
    check("flush_addr", last_wr_addr, 0);
    check("flush_data", last_wr_data, 32'h10);
    check("flush_box_done", box_cnt - b0, 1);
    check("flush_after_reads", last_wr_cyc > last_msg_cyc, 1);
    check("flush_no_overlap", rw_overlap, 0);

    // Reset asserted while the reader sits in the inter-read gap.
    m0 = rd_cnt[1];
    fifo_q.push_back(MSG_ID_YBB);
    fifo_q.push_back(corner(5, 6));
    fifo_q.push_back(corner(7, 8));
    wait_rd(1, m0 + 1, 6 * P, "rst_gap_first_read");
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check("rstgap_id_ok", id_ok, 0);
    check("rstgap_err", err_count, 0);
    check("rstgap_x_max", box_x_max, 0);
    check("rstgap_m_read", bus.m_read, 0);
    check("rstgap_m_address", bus.m_address, 0);
    reset_n = 1'b1;
    t0 = rd_total;
    k = 0;
    while (rd_total == t0 && k < 20) begin tick(); k++; end
    check("rstgap_next_read_seen", rd_total > t0, 1);
    check("rstgap_next_read_is_id", last_rd_addr, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bbox_msg_reader.md
Name: bbox_msg_reader

Overview:
- Hardware consumer of the vision core's bounding-box message FIFO, attached as an Avalon-MM master to the core's MM slave; replaces CPU polling.
- Verifies the core ID, polls the status register and drains 3-word messages (ID, min corner, max corner).
- Emits one decoded bounding box per message to downstream navigation logic and can flush the FIFO on request.

Parameters:
- POLL_INTERVAL, 1024: idle cycles between status polls (>=1).
- IMAGE_W, 640: a coordinate x >= IMAGE_W is a malformed word.
- IMAGE_H, 480: a coordinate y >= IMAGE_H is a malformed word.
- CORE_ID, 32'h1234EEE2: expected value at address 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- m_address  out  3  slave word address (0 status, 1 msg, 2 id)
- m_read  out  1  read strobe, single-cycle pulse
- m_write  out  1  write strobe, single-cycle pulse
- m_writedata  out  32  write data
- m_readdata  in  32  slave read data, fixed latency 1, no waitrequest
- flush_req  in  1  pulse; request FIFO flush
- id_ok  out  1  core ID matched
- box_valid  out  1  one-cycle pulse; box fields valid
- box_color  out  2  0 red, 1 yellow, 2 blue
- box_x_min, box_y_min, box_x_max, box_y_max  out  11 each  box corners
- box_empty  out  1  no detection (x_min > x_max or y_min > y_max)
- err_count  out  8  malformed/out-of-sync words, saturating

Behaviour:
- Reset: all outputs 0 (m_address 0, m_writedata 0, err_count 0, id_ok 0); FSM to ID_RD; poll timer 0; word index 0.
- Bus rules:
  - m_read/m_write are high for exactly 1 cycle.
  - Every strobe is followed by at least 1 cycle with m_read=0; the slave pops the FIFO only on a read rising edge.
  - m_readdata is sampled the cycle after m_read.
- FSM:
  - ID_RD: m_read, addr 2 -> ID_WAIT.
  - ID_WAIT: id_ok <= (data==CORE_ID). Match -> IDLE. Mismatch -> ID_HOLD.
  - ID_HOLD: count POLL_INTERVAL cycles, then -> ID_RD (retry forever).
  - IDLE: timer counts to POLL_INTERVAL-1, then -> ST_RD. A pending flush takes priority -> FL_WR.
  - ST_RD: m_read, addr 0 -> ST_WAIT.
  - ST_WAIT: latch words = data[15:8]. words >= 3 -> GAP. Otherwise -> IDLE with timer cleared.
  - GAP: 1 idle cycle -> MG_RD.
  - MG_RD: m_read, addr 1 -> MG_WAIT.
  - MG_WAIT: decode word per index, then:
    - index 2 complete -> EMIT.
    - else if words remaining >= 1 -> GAP.
    - else -> IDLE.
  - EMIT: box_valid=1 for 1 cycle; -> GAP if remaining >= 3, else IDLE.
  - FL_WR: m_write, addr 0, m_writedata 32'h10 -> IDLE. Word index cleared; partial message dropped.
- Decode:
  - Index 0: must equal 24-bit ASCII "RBB"=0x00524242, "YBB"=0x00594242 or "GBB"=0x00474242; sets color 0/1/2.
  - Index 1/2: x=data[26:16], y=data[10:0]. Bits [31:27] and [15:11] must be 0, x<IMAGE_W and y<IMAGE_H.
  - Malformed word: err_count+1 (saturate at 255); word index reset to 0. An index-0 failure stays at index 0, giving resync by word-by-word scanning.
- Counting: `remaining` is decremented on every MG_RD, including discarded words; never reads more than `words` latched from the last status.
- Box outputs hold their values between EMITs. box_empty is computed combinationally from the held fields.
- flush_req: latched into a pending bit; serviced only from IDLE; never interrupts a bus transaction. A second request while pending is merged.
- Reset mid-transaction: FSM restarts at ID_RD; any partial message is lost; an outstanding read response is ignored.

Decomposition:
- Shared package: register addresses (STATUS=0, MSG=1, ID=2), FLUSH_BIT=4, message ID constants for RBB/YBB/GBB, color enum, state enum.
- One natural sub-module: bbox_word_decoder.
  - Combinational: word + index -> {id_hit, color, x, y, malformed}.
  - Keeps the FSM focused on bus sequencing.

Test Plan:
- ID check: ID reads 0x1234EEE2 -> id_ok=1 and first status read appears POLL_INTERVAL cycles later. ID reads 0xDEADBEEF -> id_ok=0 and ID_RD retried after POLL_INTERVAL.
- Nominal frame: status usedw=3; words 0x00524242, {5'b0,11'd100,5'b0,11'd50}, {5'b0,11'd200,5'b0,11'd120} -> box_valid one pulse with color 0, 100/50/200/120, box_empty=0. Reads are at least 2 cycles apart.
- Empty box: YBB with min (639,479) and max (0,0) -> color 1, box_empty=1, err_count unchanged.
- Resync: usedw=5; words 0x00000123, 0x00000456, then GBB (10,10),(20,20) -> err_count=2 and one blue box emitted.
- Short FIFO: usedw=2 -> no MSG reads and return to IDLE. Out of range: x=700 -> err_count+1, no box_valid.
- Flush: flush_req during MG_WAIT -> current read completes, then a single write to addr 0 with data 0x10 from IDLE. Reset asserted in GAP -> outputs 0 on next cycle and ID_RD follows.
